// File: rtl/tl_ctrl_if.sv
// tl_ctrl_if: bus between the traffic-light controller and the light datapath.
// master = controller side (drives state/strobes), slave = datapath side.
interface tl_ctrl_if #(
  parameter int STATE_W = 4,
  parameter int CYC_W   = 8
);
  logic [STATE_W-1:0] int_flags;
  logic               ped_req;
  logic [STATE_W-1:0] state;
  logic               cnt_rst;
  logic               ped_ack;
  logic [CYC_W-1:0]   cycle_cnt;
  logic               err;

  modport master (
    input  int_flags, ped_req,
    output state, cnt_rst, ped_ack, cycle_cnt, err
  );

  modport slave (
    output int_flags, ped_req,
    input  state, cnt_rst, ped_ack, cycle_cnt, err
  );
endinterface

// File: rtl/tl_ctrl.sv
// tl_ctrl: traffic-light sequencing controller (IDLE -> INIT -> G -> Y -> R -> G).
// Drives the datapath one-hot state vector and counter-reset strobe, latches
// pedestrian requests to extend red once, counts completed R->G cycles and
// ignores datapath flags for GUARD cycles after each state entry.
// Optional feature: define TL_ERR_CHK_EN to enable the sticky protocol-error
// flag (err) with a forced re-entry of INIT on the first error.
module tl_ctrl #(
  parameter int STATE_W = 4,
  parameter int S_INIT  = 0,
  parameter int S_G     = 1,
  parameter int S_Y     = 2,
  parameter int S_R     = 3,
  parameter int GUARD   = 2,
  parameter int CYC_W   = 8
) (
  input  logic      clk,
  input  logic      reset,
  tl_ctrl_if.master bus
);

  localparam int                 GUARD_W  = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [GUARD_W-1:0] GUARD_LD = GUARD_W'(GUARD);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_INIT,
    PH_G,
    PH_Y,
    PH_R
  } phase_e;

  phase_e             phase_q;
  phase_e             phase_d;
  logic [STATE_W-1:0] state_q;
  logic               cnt_rst_q;
  logic               ped_ack_q;
  logic               ped_pending_q;
  logic               ext_q;          // current red phase has already been extended
  logic [CYC_W-1:0]   cycle_cnt_q;
  logic [GUARD_W-1:0] guard_q;

  logic               enter_d;        // a state entry happens on this edge
  logic               grant_d;        // red extension granted on this edge
  logic               cyc_inc_d;      // R -> G completes a cycle on this edge
  logic               guard_open;
  logic               flag_hit;
  logic               err_set;

  // One-hot datapath vector for a phase; IDLE drives all zeros to halt the counter.
  function automatic logic [STATE_W-1:0] phase_vec(input phase_e ph);
    logic [STATE_W-1:0] one;
    logic [STATE_W-1:0] vec;
    one = STATE_W'(1);
    case (ph)
      PH_INIT: vec = one << S_INIT;
      PH_G:    vec = one << S_G;
      PH_Y:    vec = one << S_Y;
      PH_R:    vec = one << S_R;
      default: vec = '0;
    endcase
    return vec;
  endfunction

  // The datapath compares against a stale count right after an entry, so only
  // the active state's flag is honoured, and only once the guard has run out.
  assign guard_open = (guard_q == '0);
  assign flag_hit   = guard_open & (|(bus.int_flags & state_q));

`ifdef TL_ERR_CHK_EN
  logic err_q;
  logic viol;

  // Protocol violation: any flag in IDLE, or a non-active flag once the guard is open.
  always_comb begin
    viol = 1'b0;
    if (phase_q == PH_IDLE) begin
      viol = |bus.int_flags;
    end else begin
      viol = guard_open & (|(bus.int_flags & ~state_q));
    end
  end

  assign err_set = viol & ~err_q;

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign err_set = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Next-phase decision: forced INIT on a fresh error beats any flag-driven step.
  always_comb begin
    phase_d   = phase_q;
    enter_d   = 1'b0;
    grant_d   = 1'b0;
    cyc_inc_d = 1'b0;
    if (err_set) begin
      phase_d = PH_INIT;
      enter_d = 1'b1;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d = PH_INIT;
          enter_d = 1'b1;
        end
        PH_INIT: begin
          if (flag_hit) begin
            phase_d = PH_G;
            enter_d = 1'b1;
          end
        end
        PH_G: begin
          if (flag_hit) begin
            phase_d = PH_Y;
            enter_d = 1'b1;
          end
        end
        PH_Y: begin
          if (flag_hit) begin
            phase_d = PH_R;
            enter_d = 1'b1;
          end
        end
        PH_R: begin
          if (flag_hit) begin
            enter_d = 1'b1;
            if (ped_pending_q && !ext_q) begin
              phase_d = PH_R;
              grant_d = 1'b1;
            end else begin
              phase_d   = PH_G;
              cyc_inc_d = 1'b1;
            end
          end
        end
        default: begin
          phase_d = PH_IDLE;
          enter_d = 1'b1;
        end
      endcase
    end
  end

  // Controller state, entry actions, request latch and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PH_IDLE;
      state_q       <= '0;
      cnt_rst_q     <= 1'b0;
      ped_ack_q     <= 1'b0;
      ped_pending_q <= 1'b0;
      ext_q         <= 1'b0;
      cycle_cnt_q   <= '0;
      guard_q       <= '0;
    end else begin
      cnt_rst_q <= enter_d;
      ped_ack_q <= grant_d;
      if (enter_d) begin
        phase_q <= phase_d;
        state_q <= phase_vec(phase_d);
        guard_q <= GUARD_LD;
        ext_q   <= grant_d;
      end else if (guard_q != '0) begin
        guard_q <= guard_q - GUARD_W'(1);
      end
      // A grant consumes the request even if ped_req is high in the same cycle.
      if (grant_d) begin
        ped_pending_q <= 1'b0;
      end else if (bus.ped_req) begin
        ped_pending_q <= 1'b1;
      end
      if (cyc_inc_d) begin
        cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.cnt_rst   = cnt_rst_q;
  assign bus.ped_ack   = ped_ack_q;
  assign bus.cycle_cnt = cycle_cnt_q;

  a_state_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(state_q));

endmodule

// File: doc/tl_ctrl.md
Name: tl_ctrl

Overview:
- Traffic-light sequencing controller, directly upstream of the light datapath.
- Drives the datapath's one-hot state vector and counter-reset strobe.
- Consumes the datapath's per-state done flags (int_flags) to step INIT -> G -> Y -> R -> G.
- Adds pedestrian-request latching that extends the red phase, a completed-cycle counter, and a post-transition flag guard.

Parameters:
- STATE_W, 4, width of the one-hot state vector and of int_flags.
- S_INIT, 0, bit index of the INIT (reset green) state.
- S_G, 1, bit index of GREEN.
- S_Y, 2, bit index of YELLOW.
- S_R, 3, bit index of RED.
- GUARD, 2, cycles after any state entry during which int_flags are ignored.
- CYC_W, 8, width of cycle_cnt.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- int_flags  in  STATE_W  per-state phase-done flags from the datapath; bit k is meaningful only while state[k] is high.
- ped_req  in  1  pedestrian request; a single-cycle pulse or a level, sampled every cycle.
- state  out  STATE_W  registered state; one-hot, or all-zero in IDLE.
- cnt_rst  out  1  registered one-cycle strobe that zeroes the datapath counter.
- ped_ack  out  1  one-cycle pulse when a pending request is granted.
- cycle_cnt  out  CYC_W  number of completed R->G cycles; wraps.
- err  out  1  sticky protocol error; only active under TL_ERR_CHK_EN.

Behaviour:
- Reset values: state=0 (IDLE), cnt_rst=0, ped_ack=0, cycle_cnt=0, err=0; ped_pending=0; guard counter=0.
- Internal phases: IDLE, INIT, G, Y, R. IDLE is encoded as state==0, so the datapath counter is halted.
- IDLE -> INIT: on the first clock after reset deasserts. state[S_INIT]=1 and cnt_rst=1 in the same cycle.
- Entry action for every transition, including a re-entry of R: the state register updates, cnt_rst is high for exactly that cycle, and the guard counter loads GUARD.
- Guard counter decrements to 0 one per cycle. While it is nonzero, all int_flags are ignored. Reason: the datapath evaluates its flag against the stale count for the first cycles of a new state.
- Flag-driven transitions, when the guard is 0:
  - INIT + int_flags[S_INIT] -> G.
  - G + int_flags[S_G] -> Y.
  - Y + int_flags[S_Y] -> R.
  - R + int_flags[S_R]: if ped_pending=1, re-enter R; otherwise -> G.
- Red extension: re-entering R asserts cnt_rst, pulses ped_ack, and clears ped_pending. At most one extension per red phase; the extended-R exit always goes to G.
- Flag bits for non-active states are ignored.
- Latency: flag seen high (guard 0) -> new state and cnt_rst visible after the next rising edge (1 cycle).
- ped_pending is set by ped_req=1 in any phase, including IDLE and INIT.
  - If ped_req and the grant occur in the same cycle, the grant wins: ped_pending ends 0 and ped_ack fires.
  - A ped_req arriving during an extended R stays pending for the next red phase.
- cycle_cnt increments by 1 on each R -> G transition only (not on R re-entry, not on INIT -> G). It wraps from 2^CYC_W-1 to 0.
- Reset mid-phase: everything returns to reset values immediately (asynchronous). After release the block goes through IDLE, then INIT.
- Invariant: state is never multi-hot.

Optional Feature:
- Macro TL_ERR_CHK_EN. When defined:
  - err is set and held, cleared only by reset, on either condition:
    - any int_flags bit for a non-active state is seen high while the guard is 0;
    - int_flags is nonzero while the block is in IDLE.
  - On the cycle err first sets, the FSM forces a re-entry of INIT with cnt_rst=1. ped_pending and cycle_cnt are preserved.
- When undefined: err is tied to 0, and non-active flag bits are silently ignored.

Test Plan:
- Reset release, int_flags=0 -> state=0 for 1 cycle, then state=4'b0001 with cnt_rst=1 for exactly 1 cycle, cycle_cnt=0.
- In INIT, pulse int_flags[0] one cycle after entry (guard active) -> no transition. Pulse it again at guard 0 -> next cycle state=4'b0010 and cnt_rst=1.
- Drive the full sequence INIT, G, Y, R with flags asserted at guard 0 -> states 0001, 0010, 0100, 1000, 0010; cycle_cnt=1 after the R->G step; one cnt_rst per step.
- ped_req pulse during G, then R flag -> state stays 1000, cnt_rst=1, ped_ack=1 for 1 cycle. The second R flag -> 0010. cycle_cnt increments once.
- ped_req in the same cycle as the R-exit grant -> ped_ack=1, ped_pending=0, next red phase not extended. With CYC_W=8, after 256 cycles cycle_cnt=0.
- TL_ERR_CHK_EN defined: in G at guard 0, assert int_flags=4'b0100 -> err=1 sticky, state=0001 with cnt_rst=1. Without the macro, same stimulus -> err=0, state stays 0010.
